moving_avg: RTL and testbench
=============================

# moving_avg

Streaming moving-average filter for signed 24-bit audio samples, window 2^N. It sits directly in front of a FWFT `fifo` instance used as its delay line. Each accepted sample is pre-scaled by 2^-N and pushed into the fifo. Once the fifo holds a full window, the oldest scaled sample is popped in the same cycle and subtracted from a running accumulator. The accumulator is the filter output and feeds the downstream DSP/codec path.

## Interface
Parameters:
- DATA_WIDTH, 24, sample width (signed, two's complement)
- N, 3, log2 of window length. The attached fifo must have ADDR_WIDTH = N, so depth = 2^N.

Ports:
- clk  input  1  single system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- clear  input  1  synchronous request to flush the window and zero the accumulator
- in_valid  input  1  in_data holds a sample
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  DATA_WIDTH  signed input sample
- out_valid  output  1  one-cycle pulse: out_data updated
- out_data  output  DATA_WIDTH  signed moving average (registered)
- fifo_wr  output  1  push fifo_w_data into the delay fifo
- fifo_rd  output  1  pop the delay fifo head
- fifo_w_data  output  DATA_WIDTH  scaled sample to push
- fifo_r_data  input  DATA_WIDTH  fifo head (FWFT, valid while !fifo_empty)
- fifo_empty  input  1  fifo status
- fifo_full  input  1  fifo status

## Operation
- accept = in_valid & in_ready.
- scaled = in_data >>> N (arithmetic shift; rounds toward -inf). fifo_w_data = scaled, combinationally.
- States:
  - FILL: count < 2^N.
  - RUN: window full.
  - DRAIN: flushing the fifo.
- FILL:
  - in_ready = 1.
  - On accept: fifo_wr = 1, fifo_rd = 0, acc <= acc + scaled, count <= count + 1.
  - When count reaches 2^N-1 and accept occurs -> RUN.
- RUN:
  - in_ready = 1.
  - On accept: fifo_wr = 1, fifo_rd = 1, acc <= acc + scaled - fifo_r_data.
  - The fifo sees simultaneous rd/wr while full; occupancy stays 2^N.
- DRAIN:
  - in_ready = 0, fifo_wr = 0, fifo_rd = !fifo_empty.
  - acc and count are held at 0.
  - When fifo_empty -> FILL.
- clear:
  - Asserted in any state: next state DRAIN; acc <= 0; count <= 0.
  - Any sample presented in the same cycle is not accepted: in_ready is forced 0 combinationally when clear = 1.
- out_data = acc register. out_valid <= accept, registered.
- During DRAIN, out_data = 0; out_valid pulses once on the clear cycle's next edge to publish the zero.
- Width rule: acc is DATA_WIDTH bits signed. A sum of 2^N values each in [-2^(DW-1-N), 2^(DW-1-N)-1] cannot overflow. No saturation logic.
- Consistency check (assertion only, not functional): in RUN, fifo_full = 1; in FILL, !fifo_full.

## Timing
- Reset values: state = FILL, count = 0, acc = 0, out_data = 0, out_valid = 0.
- Combinational outputs during reset:
  - in_ready = 1 only once reset deasserts.
  - fifo_wr = fifo_rd = 0 while reset is high.
- Latency: sample accepted at edge k -> out_data/out_valid reflect it after edge k (visible in cycle k+1). Throughput is 1 sample/cycle.
- fifo_wr/fifo_rd are combinational in the accept cycle. The fifo updates at the same edge as acc, and fifo_r_data is the pre-pop head, which is correct for subtraction.
- Back-to-back accepts in RUN: each cycle subtracts the then-current head.
- Reset mid-operation: the block returns to FILL immediately. The attached fifo must share the same reset so the window is empty; no drain is needed.
- DRAIN lasts occupancy cycles (≤ 2^N), then 1 cycle to return to FILL. If the fifo is already empty, DRAIN exits after 1 cycle.

## Test plan
- Reset, then eight accepts of 80 (N=3) -> out_data 10, 20, …, 80 on successive cycles; state RUN after the 8th; fifo_full = 1.
- After the window is full at 80, accept 0 -> out_data 70, fifo_rd = fifo_wr = 1 in that cycle, occupancy stays 8.
- Negative rounding: window full of -8, then -1 repeated -> each -8 scales to -1 and each -1 also scales to -1; out_data stays -8. Then accept 7 (scales to 0) -> out_data -7.
- in_valid gapped (valid every 3rd cycle) -> out_valid pulses only after accepts; out_data holds between pulses.
- clear with 5 samples in FILL -> in_ready 0 for 5 drain cycles plus 1, fifo_rd high for 5 cycles, out_data 0, then FILL with count 0. A sample asserted on the clear cycle is ignored.
- Async reset asserted mid-RUN between clock edges -> out_data, out_valid, and acc go to 0 immediately. After release, the first sample of 16 -> out_data 2.

Source files
------------

// File: rtl/moving_avg.sv
// moving_avg: streaming moving-average filter over a 2^N-sample window.
// Each accepted sample is pre-scaled by 2^-N, pushed into an external FWFT
// delay fifo and added to a running accumulator. Once the window is full the
// oldest scaled sample is popped in the same cycle and subtracted again.
module moving_avg #(
  parameter int DATA_WIDTH = 24,
  parameter int N          = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  fifo_wr,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] fifo_w_data,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_full
);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // count runs 0 .. 2^N, so it needs one bit more than N
  localparam int            CW       = N + 1;
  localparam logic [CW-1:0] WIN_LAST = CW'((1 << N) - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [1:0]                   state_q, state_d;
  logic [CW-1:0]                count_q, count_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                         out_valid_q, out_valid_d;

  logic                         accept_s;
  logic signed [DATA_WIDTH-1:0] scaled_s;
  logic signed [DATA_WIDTH-1:0] head_s;

  // Arithmetic shift rounds toward -inf, so the window sum cannot overflow.
  assign scaled_s    = $signed(in_data) >>> N;
  assign head_s      = $signed(fifo_r_data);
  assign fifo_w_data = scaled_s;
  assign out_data    = acc_q;
  assign out_valid   = out_valid_q;

  // Handshake and delay-fifo strobes; all forced quiet while reset is high.
  always_comb begin
    in_ready = 1'b0;
    accept_s = 1'b0;
    fifo_wr  = 1'b0;
    fifo_rd  = 1'b0;
    if (!reset && !clear && (state_q != ST_DRAIN)) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
    accept_s = in_valid & in_ready;
    fifo_wr  = accept_s;
    case (state_q)
      ST_RUN:   fifo_rd = accept_s;
      ST_DRAIN: fifo_rd = !reset && !fifo_empty;
      default:  fifo_rd = 1'b0;
    endcase
  end

  // Next-state, accumulator and window-count update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_valid_d = accept_s | clear;
    if (clear) begin
      state_d = ST_DRAIN;
      acc_d   = '0;
      count_d = CNT_ZERO;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept_s) begin
            acc_d   = acc_q + scaled_s;
            count_d = count_q + CNT_ONE;
            if (count_q == WIN_LAST) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_RUN: begin
          // head is the pre-pop (oldest) scaled sample
          if (accept_s) begin
            acc_d = acc_q + scaled_s - head_s;
          end else begin
            acc_d = acc_q;
          end
        end
        ST_DRAIN: begin
          acc_d   = '0;
          count_d = CNT_ZERO;
          if (fifo_empty) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_FILL;
          acc_d   = '0;
          count_d = CNT_ZERO;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      count_q     <= CNT_ZERO;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  moving_avg_chk u_chk (
    .clk_i       (clk),
    .reset_i     (reset),
    .state_i     (state_q),
    .fifo_full_i (fifo_full)
  );

endmodule

// moving_avg_chk: consistency between filter state and delay-fifo fill level.
module moving_avg_chk (
  input logic       clk_i,
  input logic       reset_i,
  input logic [1:0] state_i,
  input logic       fifo_full_i
);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  a_run_full : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_i == ST_RUN) |-> fifo_full_i);

  a_fill_not_full : assert property (@(posedge clk_i) disable iff (reset_i)
    (state_i == ST_FILL) |-> !fifo_full_i);

endmodule

// File: tb/tb_moving_avg.sv
// tb_moving_avg: randomized bench for moving_avg with a behavioural FWFT fifo
// and a window-sum reference model.
module tb_moving_avg;

  localparam int DW  = 24;
  localparam int NW  = 3;
  localparam int WIN = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [DW-1:0] fifo_w_data;
  logic [DW-1:0] fifo_r_data;
  logic          fifo_empty;
  logic          fifo_full;

  int n_vec = 0;
  int n_err = 0;
  int n_rd  = 0;

  always #5 clk = ~clk;

  moving_avg #(.DATA_WIDTH(DW), .N(NW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .fifo_wr     (fifo_wr),
    .fifo_rd     (fifo_rd),
    .fifo_w_data (fifo_w_data),
    .fifo_r_data (fifo_r_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full)
  );

  // Behavioural FWFT fifo, depth 8, sharing the DUT reset.
  logic [DW-1:0] fmem [WIN];
  int            frp, fwp, focc, ferr;

  assign fifo_r_data = fmem[frp];
  assign fifo_empty  = (focc == 0);
  assign fifo_full   = (focc == WIN);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      frp  <= 0;
      fwp  <= 0;
      focc <= 0;
    end else begin
      if (fifo_rd && focc == 0) ferr <= ferr + 1;
      if (fifo_wr && !fifo_rd && focc == WIN) ferr <= ferr + 1;
      if (fifo_wr) begin
        fmem[fwp] <= fifo_w_data;
        fwp       <= (fwp + 1) % WIN;
      end
      if (fifo_rd) frp <= (frp + 1) % WIN;
      focc <= focc + int'(fifo_wr) - int'(fifo_rd);
    end
  end

  // Reference model: scaled samples currently in the delay line.
  int            win[$];
  bit            draining;
  logic [DW-1:0] exp_out;
  logic          exp_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check strobes,
  // then advance the model to what the coming edge should produce.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic c);
    logic          acc_e;
    logic          rd_e;
    int            x;
    int            s;
    logic [DW-1:0] sc;
    @(negedge clk);
    check("out_data", 32'(out_data), 32'(exp_out));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    in_valid = v;
    in_data  = d;
    clear    = c;
    #1;
    x     = $signed(d);
    x     = x >>> NW;
    sc    = x[DW-1:0];
    acc_e = v && !c && !draining;
    rd_e  = draining ? (win.size() > 0) : (acc_e && win.size() == WIN);
    check("in_ready", 32'(in_ready), 32'(!c && !draining));
    check("fifo_wr", 32'(fifo_wr), 32'(acc_e));
    check("fifo_rd", 32'(fifo_rd), 32'(rd_e));
    if (acc_e) check("fifo_w_data", 32'(fifo_w_data), 32'(sc));
    if (fifo_rd) n_rd++;
    if (rd_e) void'(win.pop_front());
    if (acc_e) win.push_back(x);
    if (c) draining = 1'b1;
    else if (draining && !rd_e) draining = 1'b0;
    s = 0;
    foreach (win[i]) s += win[i];
    exp_out = draining ? '0 : s[DW-1:0];
    exp_ov  = acc_e | c;
  endtask

  // Assert reset immediately (may be between edges), check, then release.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    clear    = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_fifo_wr", 32'(fifo_wr), 32'(0));
    check("rst_fifo_rd", 32'(fifo_rd), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    win.delete();
    draining = 1'b0;
    exp_out  = '0;
    exp_ov   = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ferr     = 0;
    #2;
    do_reset();

    // Window fill with 80 -> 10, 20, ... 80.
    for (int i = 0; i < 8; i++) cyc(1'b1, 24'd80, 1'b0);
    @(posedge clk); #1;
    check("full_after_fill", 32'(fifo_full), 32'(1));
    cyc(1'b1, 24'd0, 1'b0);
    @(posedge clk); #1;
    check("full_after_swap", 32'(fifo_full), 32'(1));
    cyc(1'b0, 24'd0, 1'b0);
    check("out_after_swap", 32'(out_data), 32'(70));

    // Negative rounding: -8 window, then -1s, then 7.
    for (int i = 0; i < 8; i++) cyc(1'b1, 24'hFFFFF8, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 24'hFFFFFF, 1'b0);
    cyc(1'b1, 24'd7, 1'b0);
    cyc(1'b0, 24'd0, 1'b0);
    check("neg_round_out", 32'(out_data), 32'(24'hFFFFF9));

    // Gapped valid: every third cycle.
    for (int i = 0; i < 15; i++) cyc(1'b1 && (i % 3 == 0), DW'($urandom), 1'b0);

    // Random traffic with occasional clear.
    for (int i = 0; i < 120; i++)
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 15) == 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 24'd0, 1'b0);

    // Clear with five samples in FILL; sample on the clear cycle is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'($urandom), 1'b0);
    n_rd = 0;
    cyc(1'b1, 24'd123, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'($urandom), 1'b0);
    check("drain_rd_count", 32'(n_rd), 32'(5));
    cyc(1'b1, 24'd8, 1'b0);
    cyc(1'b0, 24'd0, 1'b0);
    check("refill_out", 32'(out_data), 32'(1));

    // Asynchronous reset in the middle of RUN.
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'($urandom), 1'b0);
    do_reset();
    cyc(1'b1, 24'd16, 1'b0);
    cyc(1'b0, 24'd0, 1'b0);
    check("post_reset_out", 32'(out_data), 32'(2));

    check("fifo_protocol", 32'(ferr), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
